// File: rtl/uart_pkg.sv
// Shared UART definitions used by both ends of the link: receiver state
// encoding and frame geometry.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_DONE  = 3'd4
    } rxState_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to 1 so an idle-high serial line looks idle straight out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a bit period of CLKCOUNTER+1
// clocks, one-cycle done/frameError strobes at the end of every frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKCOUNTER    = 8,
    parameter int NBITS_COUNTER = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bitRX,
    output logic [UART_DATA_BITS-1:0] dataRX,
    output logic                      done,
    output logic                      busy,
    output logic                      frameError
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [NBITS_COUNTER-1:0] HALF_CNT = NBITS_COUNTER'(CLKCOUNTER >> 1);
    localparam logic [NBITS_COUNTER-1:0] BIT_CNT  = NBITS_COUNTER'(CLKCOUNTER);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    rxState_t                  state, stateNext;
    logic [NBITS_COUNTER-1:0]  counter, counterNext;
    logic [IDX_W-1:0]          idx, idxNext;
    logic [UART_DATA_BITS-1:0] shiftReg, shiftNext;
    logic [UART_DATA_BITS-1:0] dataNext;
    logic                      errNext;
    logic                      rxSync, rxPrev;
    logic                      fallEdge;

    sync_2ff uSync (
        .clk (clk),
        .rst (rst),
        .d   (bitRX),
        .q   (rxSync)
    );

    assign fallEdge = rxPrev & ~rxSync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // RX_DONE accepts a falling edge directly so back-to-back frames lose nothing.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        idxNext     = idx;
        shiftNext   = shiftReg;
        dataNext    = dataRX;
        errNext     = 1'b0;
        case (state)
            IDLE: begin
                counterNext = '0;
                idxNext     = '0;
                if (fallEdge) begin
                    stateNext = RX_START;
                end
            end
            RX_START: begin
                if (counter == HALF_CNT) begin
                    counterNext = '0;
                    stateNext   = rxSync ? IDLE : RX_DATA;
                end else begin
                    counterNext = counter + 1'b1;
                end
            end
            RX_DATA: begin
                if (counter == BIT_CNT) begin
                    counterNext    = '0;
                    shiftNext[idx] = rxSync;
                    idxNext        = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        stateNext = RX_STOP;
                    end
                end else begin
                    counterNext = counter + 1'b1;
                end
            end
            RX_STOP: begin
                if (counter == BIT_CNT) begin
                    counterNext = '0;
                    idxNext     = '0;
                    stateNext   = RX_DONE;
                    if (rxSync) begin
                        dataNext = shiftReg;
                    end else begin
                        errNext = 1'b1;
                    end
                end else begin
                    counterNext = counter + 1'b1;
                end
            end
            RX_DONE: begin
                counterNext = '0;
                idxNext     = '0;
                stateNext   = fallEdge ? RX_START : IDLE;
            end
            default: begin
                stateNext   = IDLE;
                counterNext = '0;
                idxNext     = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxPrev     <= 1'b1;
            counter    <= '0;
            idx        <= '0;
            shiftReg   <= '0;
            dataRX     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            frameError <= 1'b0;
        end else begin
            rxPrev     <= rxSync;
            counter    <= counterNext;
            idx        <= idxNext;
            shiftReg   <= shiftNext;
            dataRX     <= dataNext;
            done       <= (stateNext == RX_DONE);
            busy       <= (stateNext == RX_START) || (stateNext == RX_DATA) ||
                          (stateNext == RX_STOP);
            frameError <= errNext;
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- UART receiver: the receive end of the link driven by the team's UART transmitter.
- Samples a serial line, recovers 8N1 frames (LSB first) and presents each byte with a one-cycle completion strobe.
- Uses the same bit-period parameterisation as the transmitter, so a TX→RX loopback with equal parameters is lossless.
- Sits between the board RX pin and byte-level consumers (FIFO, command decoder).

## Interface
- `CLKCOUNTER`, default 8: bit period is `CLKCOUNTER+1` clock cycles. Must be ≥ 2.
- `NBITS_COUNTER`, default 8: width of the internal cycle counter. Must hold `CLKCOUNTER`.
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: asynchronous, active-low reset.
- `bitRX`, input, 1: serial line, asynchronous to `clk`, idles high.
- `dataRX`, output, 8: last correctly framed byte.
- `done`, output, 1: one-cycle pulse at the end of every frame, valid or errored.
- `busy`, output, 1: high while a frame is being received.
- `frameError`, output, 1: one-cycle pulse coincident with `done` when the stop bit sampled low.

## Operation
- `bitRX` passes through a two-flop synchronizer. All logic below uses the synchronized value `rxSync` plus a one-cycle delayed copy `rxPrev`.
- `HALF = CLKCOUNTER >> 1`. `P = CLKCOUNTER + 1`.
- **IDLE**
  - Counter and bit index are held at 0.
  - Falling edge (`rxPrev`=1, `rxSync`=0) → RX_START.
  - A line held low continuously never re-triggers; a new frame needs a new falling edge.
- **RX_START**
  - Counter increments each cycle.
  - At counter==HALF: if `rxSync`=0 → RX_DATA with counter cleared. Otherwise the start was a glitch → IDLE, with no `done` and no `frameError`.
- **RX_DATA**
  - At counter==CLKCOUNTER: shift register bit [idx] ← `rxSync`, counter ← 0, idx ← idx+1.
  - After idx 7 is sampled → RX_STOP.
- **RX_STOP**
  - At counter==CLKCOUNTER, sample the stop bit.
  - 1 → `dataRX` ← shift register, go to RX_DONE.
  - 0 → `dataRX` unchanged, set the error flag, go to RX_DONE.
- **RX_DONE**
  - Lasts one cycle: `done`=1, `frameError` = the error flag, `busy`=0.
  - Then → IDLE.
- `busy` is 1 in RX_START, RX_DATA and RX_STOP, and 0 in IDLE and RX_DONE.
- Reset values: `dataRX`=0, `done`=0, `busy`=0, `frameError`=0, state IDLE, counter 0, idx 0, both synchronizer flops 1.
- Reset asserted mid-frame: everything returns to reset values immediately, and no `done` is produced for the aborted frame.
- Counter arithmetic is unsigned at `NBITS_COUNTER` width and never wraps, since it is cleared at CLKCOUNTER.

## Timing
- All outputs are registered. `dataRX` and `done` update on the same edge.
- Let t0 be the first cycle IDLE sees `rxSync`=0 after `rxSync`=1. This is 2 cycles after `bitRX` falls, due to the synchronizer.
- Start mid-bit check: t0+1+HALF.
- Data bit k sampled: t0+1+HALF+(k+1)·P.
- Stop bit sampled: t0+1+HALF+9·P.
- `done` high: cycle t0+2+HALF+9·P, width exactly 1.
- With defaults (P=9, HALF=4), `done` is high at t0+87.
- `busy` rises at t0+1 and falls in the `done` cycle.
- Back-to-back frames: a falling edge seen in the RX_DONE cycle or later is accepted. RX_DONE→IDLE→RX_START adds no gap beyond the edge detection.
- Tolerance: sampling at mid-bit gives about ±HALF/P drift margin over the 10-bit frame.

## Structure
- Shared package `uart_pkg`, shared with the transmitter:
  - RX state encodings: IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE (3-bit).
  - Frame constant `UART_DATA_BITS = 8`.
- One natural sub-module: `sync_2ff`, a two-flop synchronizer with async active-low reset to 1, instantiated on `bitRX`.
- FSM, counter and shift register stay in `uart_rx`.

## Test plan
- **Loopback.** Transmitter drives `bitRX` with 0xA5, defaults on both ends → `done` pulses once, `dataRX`=0xA5, `frameError`=0, `busy` falls on the `done` cycle.
- **Edge patterns.** Frames 0x00, then 0xFF, then 0x01, sent back-to-back with no idle gap → three `done` pulses with `dataRX` 0x00, 0xFF, 0x01 in order.
- **Glitch.** `bitRX` low for 3 cycles (less than HALF+2) then high → `busy` high for at most HALF+1 cycles, no `done`, `dataRX` unchanged.
- **Framing error.** Valid start, data 0x3C, stop bit held low → `done`=1 and `frameError`=1 in the same cycle, `dataRX` keeps the previous value. No new frame starts until the line goes high and then falls again.
- **Reset mid-frame.** `rst` pulsed low during data bit 4 → all outputs return to reset values at once, no `done`. A following 0x5A frame is received correctly.
- **Parameter sweep.** CLKCOUNTER=3 and 15, frame 0x96 → `done` at t0+2+HALF+9·P exactly, `dataRX`=0x96.
